// File: rtl/alu_result_buffer.sv
// In-order result buffer behind the 16-bit ALU: captures result, flags,
// destination and branch-taken, and hands the head entry to writeback/PC
// update under a valid/ready handshake.
module alu_result_buffer #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned REG_W = 4
) (
    input  logic                       input_CLK,
    input  logic                       input_Reset_n,
    input  logic                       input_Valid,
    output logic                       output_Ready,
    input  logic [15:0]                input_Result,
    input  logic                       input_Zero,
    input  logic                       input_Negative,
    input  logic [REG_W-1:0]           input_Dest,
    input  logic [2:0]                 input_Cond,
    input  logic                       input_Flush,
    output logic                       output_Valid,
    input  logic                       input_Ready,
    output logic [15:0]                output_Result,
    output logic                       output_Zero,
    output logic                       output_Negative,
    output logic [REG_W-1:0]           output_Dest,
    output logic                       output_Taken,
    output logic [$clog2(DEPTH):0]     output_Count
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned DATA_W = 16;

    localparam logic [2:0] COND_EQ = 3'b001;
    localparam logic [2:0] COND_NE = 3'b010;
    localparam logic [2:0] COND_LT = 3'b011;
    localparam logic [2:0] COND_GE = 3'b100;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              zero;
        logic              negative;
        logic [REG_W-1:0]  dest;
        logic              taken;
    } entry_t;

    entry_t             slots [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    logic               taken_c;
    logic               push_c;
    logic               pop_c;
    logic               ready_c;
    logic               valid_c;
    entry_t             wr_entry_c;
    entry_t             head_c;

    // Branch resolution from the incoming flags; unknown codes never branch
    always_comb begin
        taken_c = 1'b0;
        case (input_Cond)
            COND_EQ: taken_c = input_Zero;
            COND_NE: taken_c = ~input_Zero;
            COND_LT: taken_c = input_Negative;
            COND_GE: taken_c = ~input_Negative;
            default: taken_c = 1'b0;
        endcase
    end

    // Handshake qualification, all derived from registered occupancy
    always_comb begin
        ready_c               = (count < CNT_W'(DEPTH));
        valid_c               = (count != '0);
        push_c                = input_Valid & ready_c;
        pop_c                 = valid_c & input_Ready;
        wr_entry_c            = '0;
        wr_entry_c.result     = input_Result;
        wr_entry_c.zero       = input_Zero;
        wr_entry_c.negative   = input_Negative;
        wr_entry_c.dest       = input_Dest;
        wr_entry_c.taken      = taken_c;
        head_c                = valid_c ? slots[rd_ptr] : '0;
    end

    // Pointer and occupancy tracking; flush wins over push/pop
    always_ff @(posedge input_CLK or negedge input_Reset_n) begin
        if (!input_Reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (input_Flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_c, pop_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; a flushed push is dropped
    always_ff @(posedge input_CLK or negedge input_Reset_n) begin
        if (!input_Reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else if (push_c && !input_Flush) begin
            slots[wr_ptr] <= wr_entry_c;
        end
    end

    assign output_Ready    = ready_c;
    assign output_Valid    = valid_c;
    assign output_Result   = head_c.result;
    assign output_Zero     = head_c.zero;
    assign output_Negative = head_c.negative;
    assign output_Dest     = head_c.dest;
    assign output_Taken    = head_c.taken;
    assign output_Count    = count;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer with a queue-based scoreboard.
module tb_alu_result_buffer;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned REG_W = 4;

    typedef struct packed {
        logic [15:0]      r;
        logic             z;
        logic             n;
        logic [REG_W-1:0] d;
        logic             t;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             out_ready;
    logic [15:0]      in_result;
    logic             in_zero;
    logic             in_neg;
    logic [REG_W-1:0] in_dest;
    logic [2:0]       in_cond;
    logic             in_flush;
    logic             out_valid;
    logic             in_ready;
    logic [15:0]      out_result;
    logic             out_zero;
    logic             out_neg;
    logic [REG_W-1:0] out_dest;
    logic             out_taken;
    logic [1:0]       out_count;
    exp_t             dut_head;

    int checks = 0;
    int errors = 0;
    exp_t q[$];

    alu_result_buffer #(.DEPTH(DEPTH), .REG_W(REG_W)) dut (
        .input_CLK      (clk),
        .input_Reset_n  (rst_n),
        .input_Valid    (in_valid),
        .output_Ready   (out_ready),
        .input_Result   (in_result),
        .input_Zero     (in_zero),
        .input_Negative (in_neg),
        .input_Dest     (in_dest),
        .input_Cond     (in_cond),
        .input_Flush    (in_flush),
        .output_Valid   (out_valid),
        .input_Ready    (in_ready),
        .output_Result  (out_result),
        .output_Zero    (out_zero),
        .output_Negative(out_neg),
        .output_Dest    (out_dest),
        .output_Taken   (out_taken),
        .output_Count   (out_count)
    );

    assign dut_head = {out_result, out_zero, out_neg, out_dest, out_taken};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic taken_of(input logic [2:0] c, input logic z, input logic n);
        case (c)
            3'd1:    return z;
            3'd2:    return !z;
            3'd3:    return n;
            3'd4:    return !n;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // State check against the scoreboard, taken at the falling edge
    task automatic chk_state(input string tag);
        exp_t h;
        h = (q.size() != 0) ? q[0] : '0;
        chk({tag, "_count"}, 32'(out_count), 32'(q.size()));
        chk({tag, "_valid"}, 32'(out_valid), 32'(q.size() != 0));
        chk({tag, "_ready"}, 32'(out_ready), 32'(q.size() < DEPTH));
        chk({tag, "_head"},  32'(dut_head),  32'(h));
    endtask

    // One clock: drive at negedge, predict, cross posedge, check at next negedge
    task automatic step(input string tag, input logic v, input logic [15:0] r,
                        input logic z, input logic n, input logic [REG_W-1:0] d,
                        input logic [2:0] c, input logic rdy, input logic fl);
        logic push;
        logic pop;
        exp_t e;
        in_valid  = v;
        in_result = r;
        in_zero   = z;
        in_neg    = n;
        in_dest   = d;
        in_cond   = c;
        in_ready  = rdy;
        in_flush  = fl;
        push = v && (q.size() < DEPTH);
        pop  = rdy && (q.size() != 0);
        e = '{r: r, z: z, n: n, d: d, t: taken_of(c, z, n)};
        if (pop) chk({tag, "_pop"}, 32'(dut_head), 32'(q[0]));
        if (fl) begin
            q.delete();
        end else begin
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        chk_state(tag);
    endtask

    task automatic idle(input string tag, input logic rdy);
        step(tag, 1'b0, 16'h0, 1'b0, 1'b0, '0, 3'd0, rdy, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_result = '0;
        in_zero   = 1'b0;
        in_neg    = 1'b0;
        in_dest   = '0;
        in_cond   = '0;
        in_ready  = 1'b0;
        in_flush  = 1'b0;
        repeat (3) @(negedge clk);
        chk_state("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // First capture, EQ with zero set
        step("push0", 1'b1, 16'h0000, 1'b1, 1'b0, 4'd3, 3'd1, 1'b0, 1'b0);
        chk("push0_taken", 32'(out_taken), 32'd1);
        chk("push0_dest",  32'(out_dest),  32'd3);

        // Replace head with 0x8001 (LT), add 0x0005 (GE), fill to full
        step("pp_8001", 1'b1, 16'h8001, 1'b0, 1'b1, 4'd5, 3'd3, 1'b1, 1'b0);
        step("push_0005", 1'b1, 16'h0005, 1'b0, 1'b0, 4'd6, 3'd4, 1'b0, 1'b0);
        chk("full_ready", 32'(out_ready), 32'd0);
        chk("full_count", 32'(out_count), 32'd2);
        step("drop_1234", 1'b1, 16'h1234, 1'b0, 1'b0, 4'd7, 3'd0, 1'b0, 1'b0);
        chk("drop_head", 32'(out_result), 32'h8001);
        idle("pop1", 1'b1);
        chk("pop1_head", 32'(out_result), 32'h0005);
        chk("pop1_taken", 32'(out_taken), 32'd1);
        idle("pop2", 1'b1);
        chk("empty_result", 32'(out_result), 32'd0);

        // Streaming at occupancy 1 across pointer wrap
        step("s_fill", 1'b1, 16'h0001, 1'b0, 1'b0, 4'd1, 3'd0, 1'b0, 1'b0);
        for (int i = 2; i <= 7; i++) begin
            step("stream", 1'b1, 16'(i), 1'b0, 1'b0, 4'(i), 3'd2, 1'b1, 1'b0);
            chk("stream_count", 32'(out_count), 32'd1);
            chk("stream_head", 32'(out_result), 32'(i));
        end
        idle("s_drain", 1'b1);

        // Flush overrides a simultaneous push
        step("f_a", 1'b1, 16'h00aa, 1'b0, 1'b0, 4'd2, 3'd0, 1'b0, 1'b0);
        step("f_b", 1'b1, 16'h00bb, 1'b0, 1'b0, 4'd4, 3'd0, 1'b0, 1'b0);
        step("flush", 1'b1, 16'h7777, 1'b0, 1'b0, 4'd9, 3'd1, 1'b0, 1'b1);
        chk("flush_count", 32'(out_count), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        idle("post_flush", 1'b1);
        chk("no_7777", 32'(out_result), 32'd0);

        // Conditions that must not branch
        step("ne_z1", 1'b1, 16'h0000, 1'b1, 1'b0, 4'd8, 3'd2, 1'b0, 1'b0);
        chk("ne_taken", 32'(out_taken), 32'd0);
        step("c101", 1'b1, 16'h0042, 1'b0, 1'b1, 4'd10, 3'd5, 1'b1, 1'b0);
        chk("c101_taken", 32'(out_taken), 32'd0);
        idle("c_drain", 1'b1);

        // Asynchronous reset with two entries buffered
        step("r_a", 1'b1, 16'h1111, 1'b0, 1'b0, 4'd1, 3'd0, 1'b0, 1'b0);
        step("r_b", 1'b1, 16'h2222, 1'b1, 1'b0, 4'd2, 3'd1, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid",  32'(out_valid),  32'd0);
        chk("arst_result", 32'(out_result), 32'd0);
        chk("arst_count",  32'(out_count),  32'd0);
        chk("arst_dest",   32'(out_dest),   32'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_state("post_rst");
        idle("post_rst_idle", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_result_buffer.md
Name: alu_result_buffer

Overview:
- Downstream stage of the 16-bit ALU in the multi-cycle datapath.
- Captures each ALU result with its zero/negative flags, destination register and branch condition code into a small in-order FIFO.
- Evaluates branch-taken at capture time.
- Presents the head entry to the writeback/PC-update logic under a valid/ready handshake.

Parameters:
- DEPTH, 2, number of buffered entries; power of two, minimum 2.
- REG_W, 4, width of the destination register index.

Ports:
- input_CLK  input  1  clock; all state updates on the rising edge.
- input_Reset_n  input  1  asynchronous, active-low reset.
- input_Valid  input  1  upstream has a result this cycle.
- output_Ready  output  1  buffer can accept an entry this cycle.
- input_Result  input  16  ALU output word.
- input_Zero  input  1  ALU zero flag.
- input_Negative  input  1  ALU negative flag.
- input_Dest  input  REG_W  destination register index.
- input_Cond  input  3  branch condition: 000 none, 001 EQ, 010 NE, 011 LT, 100 GE; 101–111 treated as none.
- input_Flush  input  1  synchronous clear of all entries.
- output_Valid  output  1  head entry present.
- input_Ready  input  1  downstream consumes the head this cycle.
- output_Result  output  16  head result.
- output_Zero  output  1  head zero flag.
- output_Negative  output  1  head negative flag.
- output_Dest  output  REG_W  head destination index.
- output_Taken  output  1  head branch-taken bit.
- output_Count  output  log2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (input_Reset_n low, asynchronous): count=0, read/write pointers=0, all storage cleared. output_Valid=0, all data outputs 0, output_Count=0.
- output_Ready = (count < DEPTH). Purely from registered state; no combinational path from input_Ready.
- push = input_Valid & output_Ready. pop = output_Valid & input_Ready.
- Push: at the clock edge, write {Result, Zero, Negative, Dest, Taken} to slot[wr_ptr]; wr_ptr wraps modulo DEPTH.
- Taken is computed at push:
  - EQ → Zero
  - NE → !Zero
  - LT → Negative
  - GE → !Negative
  - none → 0
- Pop: at the clock edge, rd_ptr advances and wraps modulo DEPTH.
- Latency: an entry pushed at edge N into an empty buffer has output_Valid=1 and its data on the outputs during cycle N+1. No same-cycle bypass.
- Occupancy states:
  - EMPTY (count=0): push → PARTIAL; pop impossible.
  - PARTIAL (0<count<DEPTH): push only → count+1; pop only → count-1; push and pop together → count unchanged, both pointers advance.
  - FULL (count=DEPTH): output_Ready=0, so no push; pop → count-1.
- Simultaneous push+pop on a 1-entry buffer: the popped entry leaves, the new entry becomes head next cycle, output_Valid stays 1.
- Outputs: output_Valid = (count != 0). Data outputs show slot[rd_ptr] when valid and are forced to 0 when empty.
- Head stability: while output_Valid=1 and input_Ready=0, all head outputs hold stable.
- Flush: input_Flush high at an edge sets count and pointers to 0 and output_Valid to 0 next cycle. Flush overrides any push or pop in that cycle, and the pushed entry is discarded.
- Reset mid-operation: asynchronously discards every entry; no partial writes survive.
- Error handling: input_Valid while output_Ready=0 is ignored; the data is not stored and no error is flagged.

Test Plan:
- Reset, then push {Result=0x0000, Zero=1, Neg=0, Dest=3, Cond=EQ}, hold input_Ready=0 → next cycle output_Valid=1, output_Result=0x0000, output_Dest=3, output_Taken=1, output_Count=1.
- Push 0x8001 (Neg=1, Cond=LT), then 0x0005 (Cond=GE), input_Ready=0 → output_Count=2, output_Ready=0. A third push of 0x1234 is dropped. Pop twice in order → 0x8001 with Taken=1, then 0x0005 with Taken=1, then output_Valid=0 with outputs 0.
- With 1 entry, push and pop every cycle for 6 cycles (values 0x0001..0x0006) → output_Count stays 1 and the outputs sequence in order. Pointer wrap-around is exercised.
- Two entries buffered, assert input_Flush together with input_Valid (0x7777) → next cycle output_Count=0, output_Valid=0, and 0x7777 never appears.
- Cond=NE with Zero=1, and Cond=101 with Zero=0 → output_Taken=0 in both cases.
- Two entries buffered, drop input_Reset_n mid-cycle → outputs go to 0 immediately, without waiting for a clock edge. After release, output_Ready=1 and output_Count=0.
